// File: rtl/pix_pack_pkg.sv
// Shared types and constants for the 24-bit pixel to 64-bit word packer.
package pix_pack_pkg;

   localparam int unsigned PIX_W  = 24;
   localparam int unsigned WORD_W = 64;
   localparam int unsigned ACC_W  = 128;
   localparam int unsigned FILL_W = 7;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH_WAIT,
      FLUSH_EMIT
   } state_e;

   // Ones in bit positions below fill, used to zero-pad a partial word.
   function automatic logic [WORD_W-1:0] low_mask(input logic [FILL_W-1:0] fill);
      logic [WORD_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < WORD_W; i++) begin
         if (i < 32'(fill)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/pix_obuf.sv
// First-word-fall-through word FIFO with occupancy output; head reads 0 when empty.
module pix_obuf
   import pix_pack_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = WORD_W
) (
   input  logic                     afi_clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_pop;

   always_comb begin
      do_pop   = pop && (level_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, do_pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge afi_clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge afi_clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign level = level_q;

   // The packer's request throttling must make a push into a full buffer impossible.
   a_no_overflow: assert property (@(posedge afi_clk) disable iff (!rstn)
      !(push && !do_pop && (level_q == (AW+1)'(DEPTH))));

endmodule

// File: rtl/pix_pack64.sv
// Packs 24-bit FIFO samples LSB-first into 64-bit words (8 samples -> 3 words).
// Define PIX_PACK_STATS_EN to add sample_cnt / word_cnt statistics outputs.
module pix_pack64
   import pix_pack_pkg::*;
#(
   parameter int unsigned OBUF_DEPTH = 4,
   parameter int unsigned USEDW_W    = 8
) (
   input  logic                            afi_clk,
   input  logic                            rstn,
   input  logic                            enable,
   input  logic                            flush,
   output logic                            rd_fifo_req,
   input  logic [PIX_W-1:0]                w_data,
   input  logic [USEDW_W-1:0]              rd_usedw,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WORD_W-1:0]               out_data,
   output logic [$clog2(OBUF_DEPTH):0]     out_level,
   output logic                            flush_done,
`ifdef PIX_PACK_STATS_EN
   output logic [31:0]                     sample_cnt,
   output logic [31:0]                     word_cnt,
`endif
   output logic                            busy
);

   localparam int unsigned LW = $clog2(OBUF_DEPTH) + 1;

   state_e            state_q, state_d;
   logic              inflight_q, inflight_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              flush_done_q, flush_done_d;

   logic [ACC_W-1:0]  acc_ins;
   logic [FILL_W-1:0] fill_ins;
   logic [LW-1:0]     level;
   logic [LW-1:0]     free;
   logic              req;
   logic              push;
   logic [WORD_W-1:0] push_data;
   logic              pop;
   logic [WORD_W-1:0] head;

   pix_obuf #(
      .DEPTH (OBUF_DEPTH),
      .WIDTH (WORD_W)
   ) u_obuf (
      .afi_clk   (afi_clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .level     (level)
   );

   assign free = LW'(OBUF_DEPTH) - level;
   assign pop  = (level != '0) && out_ready;

   // Two free slots cover the word the in-flight sample may still produce.
   always_comb begin
      req = (state_q == RUN) && enable
            && (rd_usedw > USEDW_W'(inflight_q))
            && (free >= LW'(2));
   end

   always_comb begin
      acc_ins  = acc_q;
      fill_ins = fill_q;
      if (inflight_q) begin
         acc_ins  = acc_q | (ACC_W'(w_data) << fill_q);
         fill_ins = fill_q + FILL_W'(PIX_W);
      end

      acc_d     = acc_ins;
      fill_d    = fill_ins;
      push      = 1'b0;
      push_data = acc_ins[WORD_W-1:0];
      if (fill_ins >= FILL_W'(WORD_W)) begin
         push   = 1'b1;
         acc_d  = acc_ins >> WORD_W;
         fill_d = fill_ins - FILL_W'(WORD_W);
      end

      inflight_d   = req;
      state_d      = state_q;
      flush_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (flush)       state_d = FLUSH_WAIT;
            else if (enable) state_d = RUN;
         end
         RUN: begin
            if (flush)        state_d = FLUSH_WAIT;
            else if (!enable) state_d = IDLE;
         end
         FLUSH_WAIT: begin
            if (!inflight_q && (free >= LW'(1))) begin
               state_d      = FLUSH_EMIT;
               flush_done_d = 1'b1;
            end
         end
         FLUSH_EMIT: begin
            // No sample is in flight here, so acc_q/fill_q are final.
            if (fill_q != '0) begin
               push      = 1'b1;
               push_data = acc_q[WORD_W-1:0] & low_mask(fill_q);
            end
            acc_d   = '0;
            fill_d  = '0;
            state_d = enable ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge afi_clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         inflight_q   <= 1'b0;
         fill_q       <= '0;
         acc_q        <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         inflight_q   <= inflight_d;
         fill_q       <= fill_d;
         acc_q        <= acc_d;
         flush_done_q <= flush_done_d;
      end
   end

`ifdef PIX_PACK_STATS_EN
   logic [31:0] sample_cnt_q, sample_cnt_d;
   logic [31:0] word_cnt_q, word_cnt_d;

   always_comb begin
      sample_cnt_d = sample_cnt_q + (inflight_q ? 32'd1 : 32'd0);
      word_cnt_d   = word_cnt_q + (pop ? 32'd1 : 32'd0);
      if (state_q == FLUSH_EMIT) begin
         sample_cnt_d = '0;
         word_cnt_d   = '0;
      end
   end

   always_ff @(posedge afi_clk or negedge rstn) begin
      if (!rstn) begin
         sample_cnt_q <= '0;
         word_cnt_q   <= '0;
      end else begin
         sample_cnt_q <= sample_cnt_d;
         word_cnt_q   <= word_cnt_d;
      end
   end

   assign sample_cnt = sample_cnt_q;
   assign word_cnt   = word_cnt_q;
`endif

   assign rd_fifo_req = req;
   assign out_valid   = (level != '0);
   assign out_data    = head;
   assign out_level   = level;
   assign flush_done  = flush_done_q;
   assign busy        = (state_q != IDLE) || (fill_q != '0) || (level != '0);

endmodule

// File: tb/tb_pix_pack64.sv
// Directed bench for pix_pack64: vector table for full 8-sample packing plus hand sequences.
`timescale 1ns/1ps
module tb_pix_pack64;

   localparam int unsigned OBUF_DEPTH = 4;
   localparam int unsigned USEDW_W    = 8;
   localparam int unsigned LW         = $clog2(OBUF_DEPTH) + 1;

   logic               afi_clk = 1'b0;
   logic               rstn;
   logic               enable;
   logic               flush;
   logic               rd_fifo_req;
   logic [23:0]        w_data = '0;
   logic [USEDW_W-1:0] rd_usedw;
   logic               out_valid;
   logic               out_ready;
   logic [63:0]        out_data;
   logic [LW-1:0]      out_level;
   logic               flush_done;
   logic               busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Source FIFO model: initial block writes wr_idx, model writes rd_idx.
   logic [23:0]        src_mem [1024];
   int                 wr_idx = 0;
   int                 rd_idx = 0;
   int                 reads  = 0;
   logic               ovr_en = 1'b0;
   logic [USEDW_W-1:0] ovr_val = '0;

   // Output capture, written only by the monitor.
   logic [63:0]        got_w [512];
   int                 got_n = 0;
   int                 fd_pulses = 0;
   int                 req_n = 0;
   int unsigned        max_level = 0;

   typedef struct {
      string            name;
      logic [7:0][23:0] s;
      logic [2:0][63:0] w;
   } vec_t;

   vec_t        vecs [3];
   logic [959:0] stream;
   int          base, base2, fd0, r0, rq0, n_rd;

   always #5 afi_clk = ~afi_clk;

   pix_pack64 #(
      .OBUF_DEPTH (OBUF_DEPTH),
      .USEDW_W    (USEDW_W)
   ) dut (
      .afi_clk     (afi_clk),
      .rstn        (rstn),
      .enable      (enable),
      .flush       (flush),
      .rd_fifo_req (rd_fifo_req),
      .w_data      (w_data),
      .rd_usedw    (rd_usedw),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_level   (out_level),
      .flush_done  (flush_done),
      .busy        (busy)
   );

   assign rd_usedw = ovr_en ? ovr_val : USEDW_W'(wr_idx - rd_idx);

   always @(posedge afi_clk) begin
      if (rd_fifo_req) begin
         reads <= reads + 1;
         if (rd_idx < wr_idx) begin
            w_data <= src_mem[rd_idx];
            rd_idx <= rd_idx + 1;
         end else begin
            w_data <= '0;
         end
      end
   end

   always @(negedge afi_clk) begin
      if (rstn && out_valid && out_ready) begin
         got_w[got_n] <= out_data;
         got_n        <= got_n + 1;
      end
      if (rstn && flush_done) fd_pulses <= fd_pulses + 1;
      if (rd_fifo_req) req_n <= req_n + 1;
      if (32'(out_level) > max_level) max_level <= 32'(out_level);
   end

   task automatic step(input int n);
      repeat (n) @(posedge afi_clk);
      #2;
   endtask

   task automatic load(input logic [23:0] s);
      src_mem[wr_idx] = s;
      wr_idx = wr_idx + 1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_words(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (got_n < target && k < budget) begin
         step(1);
         k++;
      end
      if (got_n < target) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got %0d words expected %0d", name, got_n, target);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   64'(rd_fifo_req), 64'd0);
      check({tag, "_valid"}, 64'(out_valid),   64'd0);
      check({tag, "_data"},  out_data,         64'd0);
      check({tag, "_level"}, 64'(out_level),   64'd0);
      check({tag, "_fdone"}, 64'(flush_done),  64'd0);
      check({tag, "_busy"},  64'(busy),        64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d words", got_n);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0].name = "pack_seq";
      vecs[0].s = {24'h888888, 24'h777777, 24'h666666, 24'h555555,
                   24'h444444, 24'h333333, 24'h222222, 24'h111111};
      vecs[0].w = {64'h8888887777776666, 64'h6655555544444433, 64'h3333222222111111};
      vecs[1].name = "pack_alt";
      vecs[1].s = {24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF,
                   24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
      vecs[1].w = {64'h000000FFFFFF0000, 64'h00FFFFFF000000FF, 64'hFFFF000000FFFFFF};
      vecs[2].name = "pack_small";
      vecs[2].s = {24'h000008, 24'h000007, 24'h000006, 24'h000005,
                   24'h000004, 24'h000003, 24'h000002, 24'h000001};
      vecs[2].w = {64'h0000080000070000, 64'h0600000500000400, 64'h0003000002000001};

      rstn      = 1'b0;
      enable    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #1;
      check_reset_outputs("rst0");
      step(3);
      rstn = 1'b1;
      step(2);

      // Full 8-sample groups, consumer always ready.
      enable    = 1'b1;
      out_ready = 1'b1;
      for (int v = 0; v < 3; v++) begin
         base = got_n;
         for (int i = 0; i < 8; i++) load(vecs[v].s[i]);
         wait_words(base + 3, 60, vecs[v].name);
         for (int j = 0; j < 3; j++)
            check($sformatf("%s_w%0d", vecs[v].name, j), got_w[base + j], vecs[v].w[j]);
      end
      step(4);
      enable = 1'b0;
      step(3);
      @(negedge afi_clk);
      check("pack_idle_busy", 64'(busy), 64'd0);

      // Partial flush of 3 samples.
      step(1);
      enable = 1'b1;
      base   = got_n;
      fd0    = fd_pulses;
      load(24'h111111);
      load(24'h222222);
      load(24'h333333);
      step(8);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      wait_words(base + 2, 20, "pflush");
      check("pflush_w0", got_w[base],     64'h3333222222111111);
      check("pflush_w1", got_w[base + 1], 64'h0000000000000033);
      step(4);
      check("pflush_fdone_cnt", 64'(fd_pulses - fd0), 64'd1);

      // Flush with fill=0 while 3 words sit in the buffer.
      out_ready = 1'b0;
      base = got_n;
      for (int i = 0; i < 8; i++) load(vecs[0].s[i]);
      step(20);
      @(negedge afi_clk);
      check("f0_level_pre", 64'(out_level), 64'd3);
      step(1);
      flush = 1'b1;
      @(negedge afi_clk);
      check("f0_fdone_c0", 64'(flush_done), 64'd0);
      step(1);
      flush = 1'b0;
      @(negedge afi_clk);
      check("f0_fdone_c1", 64'(flush_done), 64'd0);
      step(1);
      @(negedge afi_clk);
      check("f0_fdone_c2", 64'(flush_done), 64'd1);
      step(1);
      @(negedge afi_clk);
      check("f0_fdone_c3", 64'(flush_done), 64'd0);
      check("f0_level_post", 64'(out_level), 64'd3);
      step(1);
      out_ready = 1'b1;
      wait_words(base + 3, 20, "f0_drain");
      for (int j = 0; j < 3; j++)
         check($sformatf("f0_w%0d", j), got_w[base + j], vecs[0].w[j]);
      step(4);

      // Backpressure with 40 samples available.
      out_ready = 1'b0;
      base = got_n;
      r0   = reads;
      for (int i = 0; i < 40; i++) begin
         logic [23:0] smp;
         smp = 24'h0A0B0C + 24'(i) * 24'h010203;
         load(smp);
         stream[i*24 +: 24] = smp;
      end
      step(30);
      rq0 = req_n;
      step(10);
      @(negedge afi_clk);
      n_rd = reads - r0;
      check("bp_max_level_le4", 64'(max_level <= 32'd4), 64'd1);
      check("bp_req_low", 64'(rd_fifo_req), 64'd0);
      check("bp_no_reqs_window", 64'(req_n - rq0), 64'd0);
      check("bp_level_vs_reads", 64'(out_level), 64'((n_rd * 24) / 64));
      step(1);
      out_ready = 1'b1;
      wait_words(base + 15, 200, "bp_drain");
      for (int k = 0; k < 15; k++)
         check($sformatf("bp_w%0d", k), got_w[base + k], stream[k*64 +: 64]);
      step(4);

      // Underrun: occupancy pinned at 1 allows only one outstanding read.
      base    = got_n;
      fd0     = fd_pulses;
      ovr_val = 8'd1;
      ovr_en  = 1'b1;
      load(24'h123456);
      load(24'h789ABC);
      @(negedge afi_clk);
      check("ur_req_first", 64'(rd_fifo_req), 64'd1);
      step(1);
      @(negedge afi_clk);
      check("ur_req_inflight", 64'(rd_fifo_req), 64'd0);
      ovr_en = 1'b0;
      step(6);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      wait_words(base + 1, 20, "ur_flush");
      check("ur_flush_w0", got_w[base], 64'h0000789ABC123456);
      step(4);
      check("ur_fdone_cnt", 64'(fd_pulses - fd0), 64'd1);

      // Reset mid-stream with fill=48 and two held words.
      out_ready = 1'b0;
      base = got_n;
      for (int i = 0; i < 8; i++) load(vecs[0].s[i]);
      step(20);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      load(24'h5A5A5A);
      load(24'hA5A5A5);
      step(6);
      @(negedge afi_clk);
      check("mr_level_pre", 64'(out_level), 64'd2);
      check("mr_popped_w0", got_w[base], vecs[0].w[0]);
      #1;
      rstn = 1'b0;
      #1;
      check_reset_outputs("mr");
      wr_idx = rd_idx;
      step(2);
      base2 = got_n;
      @(negedge afi_clk);
      rstn = 1'b1;
      step(1);
      load(24'hAAAAAA);
      load(24'hBBBBBB);
      load(24'hCCCCCC);
      out_ready = 1'b1;
      wait_words(base2 + 1, 30, "mr_post");
      check("mr_post_w0", got_w[base2], 64'hCCCCBBBBBBAAAAAA);

      step(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
